// File: rtl/matmul_job_arbiter.sv
// rtl/matmul_job_arbiter.sv - whole-job arbiter sharing one matmul datapath between requesters
//
// Purpose:
//   Grants the single matmul instance to one requester for a complete matrix job.
//   The owner keeps the A, B and C streams until its last C beat is accepted.
//   Data is muxed/broadcast combinationally; only handshakes are gated.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   job_req / job_done       per-requester level request / one-cycle completion pulse
//   grant_valid / grant_id   job in progress / current owner index
//   req_a_*, req_b_*         per-requester A/B tile streams (data packed at [i*W +: W])
//   req_out_*                C tile stream back to requesters (data broadcast)
//   mm_a_*, mm_b_*, mm_out_* streams to/from the shared matmul instance
//
// Build option:
//   MATMUL_ARB_FIXED_PRIORITY_EN defined   -> lowest-index active request always wins.
//   MATMUL_ARB_FIXED_PRIORITY_EN undefined -> round-robin, search starts after the last owner.

module matmul_job_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int A_TOTAL_DIM0   = 4,
    parameter int A_TOTAL_DIM1   = 4,
    parameter int B_TOTAL_DIM0   = 4,
    parameter int A_COMPUTE_DIM0 = 2,
    parameter int A_COMPUTE_DIM1 = 2,
    parameter int B_COMPUTE_DIM0 = 2,
    parameter int A_WIDTH        = 8,
    parameter int B_WIDTH        = 8,
    parameter int OUT_WIDTH      = 16,
    localparam int AF   = A_WIDTH * A_COMPUTE_DIM0 * A_COMPUTE_DIM1,
    localparam int BF   = B_WIDTH * B_COMPUTE_DIM0 * A_COMPUTE_DIM0,
    localparam int CF   = OUT_WIDTH * B_COMPUTE_DIM0 * A_COMPUTE_DIM1,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [NUM_REQ-1:0]    job_req,
    output logic [NUM_REQ-1:0]    job_done,
    output logic                  grant_valid,
    output logic [ID_W-1:0]       grant_id,

    input  logic [NUM_REQ*AF-1:0] req_a_data,
    input  logic [NUM_REQ-1:0]    req_a_valid,
    output logic [NUM_REQ-1:0]    req_a_ready,
    input  logic [NUM_REQ*BF-1:0] req_b_data,
    input  logic [NUM_REQ-1:0]    req_b_valid,
    output logic [NUM_REQ-1:0]    req_b_ready,
    output logic [CF-1:0]         req_out_data,
    output logic [NUM_REQ-1:0]    req_out_valid,
    input  logic [NUM_REQ-1:0]    req_out_ready,

    output logic [AF-1:0]         mm_a_data,
    output logic                  mm_a_valid,
    input  logic                  mm_a_ready,
    output logic [BF-1:0]         mm_b_data,
    output logic                  mm_b_valid,
    input  logic                  mm_b_ready,
    input  logic [CF-1:0]         mm_out_data,
    input  logic                  mm_out_valid,
    output logic                  mm_out_ready
);

    localparam int A_BEATS   = (A_TOTAL_DIM0 / A_COMPUTE_DIM0) * (A_TOTAL_DIM1 / A_COMPUTE_DIM1);
    localparam int B_BEATS   = (B_TOTAL_DIM0 / B_COMPUTE_DIM0) * (A_TOTAL_DIM0 / A_COMPUTE_DIM0);
    localparam int C_BEATS   = (B_TOTAL_DIM0 / B_COMPUTE_DIM0) * (A_TOTAL_DIM1 / A_COMPUTE_DIM1);
    localparam int MAX_AB    = (A_BEATS > B_BEATS) ? A_BEATS : B_BEATS;
    localparam int MAX_BEATS = (MAX_AB > C_BEATS) ? MAX_AB : C_BEATS;
    localparam int CNT_W     = $clog2(MAX_BEATS + 1);

    localparam logic [CNT_W-1:0] A_FULL = CNT_W'(A_BEATS);
    localparam logic [CNT_W-1:0] B_FULL = CNT_W'(B_BEATS);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(C_BEATS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e            state_q;
    logic              grant_valid_q;
    logic [ID_W-1:0]   grant_id_q;
    logic [ID_W-1:0]   grant_id_d;
    logic              win_found;
    logic [CNT_W-1:0]  a_cnt_q;
    logic [CNT_W-1:0]  b_cnt_q;
    logic [CNT_W-1:0]  c_cnt_q;

    logic              running;
    logic              a_open;
    logic              b_open;
    logic              a_hs;
    logic              b_hs;
    logic              c_hs;
    logic              c_last;
    logic              owner_out_ready;

    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;

    // ------------------------------------------------------------------
    // Winner selection (evaluated in IDLE only)
    // ------------------------------------------------------------------
`ifdef MATMUL_ARB_FIXED_PRIORITY_EN
    always_comb begin
        win_found  = 1'b0;
        grant_id_d = '0;
        // Descending scan so the lowest active index is the last one written.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (job_req[i]) begin
                win_found  = 1'b1;
                grant_id_d = ID_W'(i);
            end
        end
    end
`else
    logic [ID_W-1:0] rr_q;
    logic [ID_W-1:0] rr_d;

    always_comb begin
        win_found  = 1'b0;
        grant_id_d = '0;
        // Scan offsets far-to-near from the pointer so the nearest active
        // requester (offset 0 first) ends up as the winner.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(rr_q) + k) % NUM_REQ;
            if (job_req[idx]) begin
                win_found  = 1'b1;
                grant_id_d = ID_W'(idx);
            end
        end
    end

    // Pointer moves to the requester after the one finishing its job.
    assign rr_d = ID_W'((int'(grant_id_q) + 1) % NUM_REQ);
`endif

    // ------------------------------------------------------------------
    // Handshake gating and muxing
    // ------------------------------------------------------------------
    assign running = (state_q == RUN);

    // Once a stream has delivered its full beat count it stays closed until
    // the job ends, so a misbehaving owner can never push extra tiles.
    assign a_open = running && (a_cnt_q != A_FULL);
    assign b_open = running && (b_cnt_q != B_FULL);

    assign mm_a_data  = req_a_data[int'(grant_id_q) * AF +: AF];
    assign mm_b_data  = req_b_data[int'(grant_id_q) * BF +: BF];
    assign mm_a_valid = a_open && req_a_valid[grant_id_q];
    assign mm_b_valid = b_open && req_b_valid[grant_id_q];

    assign owner_out_ready = req_out_ready[grant_id_q];
    // Outside a job the matmul output is not consumed; valid there is a system error.
    assign mm_out_ready    = running && owner_out_ready;
    assign req_out_data    = mm_out_data;

    assign a_hs   = mm_a_valid && mm_a_ready;
    assign b_hs   = mm_b_valid && mm_b_ready;
    assign c_hs   = running && mm_out_valid && owner_out_ready;
    assign c_last = c_hs && (c_cnt_q == C_LAST);

    always_comb begin
        req_a_ready   = '0;
        req_b_ready   = '0;
        req_out_valid = '0;
        job_done      = '0;
        req_a_ready[grant_id_q]   = a_open && mm_a_ready;
        req_b_ready[grant_id_q]   = b_open && mm_b_ready;
        req_out_valid[grant_id_q] = running && mm_out_valid;
        job_done[grant_id_q]      = c_last;
    end

    // ------------------------------------------------------------------
    // Job FSM, owner registers and beat counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            a_cnt_q       <= '0;
            b_cnt_q       <= '0;
            c_cnt_q       <= '0;
`ifndef MATMUL_ARB_FIXED_PRIORITY_EN
            rr_q          <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        state_q       <= RUN;
                        grant_valid_q <= 1'b1;
                        grant_id_q    <= grant_id_d;
                    end
                end
                RUN: begin
                    if (c_last) begin
                        // Job complete: the mandatory idle cycle follows because
                        // arbitration only happens from IDLE.
                        state_q       <= IDLE;
                        grant_valid_q <= 1'b0;
                        a_cnt_q       <= '0;
                        b_cnt_q       <= '0;
                        c_cnt_q       <= '0;
`ifndef MATMUL_ARB_FIXED_PRIORITY_EN
                        rr_q          <= rr_d;
`endif
                    end else begin
                        if (a_hs) a_cnt_q <= a_cnt_q + 1'b1;
                        if (b_hs) b_cnt_q <= b_cnt_q + 1'b1;
                        if (c_hs) c_cnt_q <= c_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    grant_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_job_arbiter.sv
// tb/tb_matmul_job_arbiter.sv - directed self-checking bench for matmul_job_arbiter
module tb_matmul_job_arbiter;

    localparam int AF = 32;
    localparam int BF = 32;
    localparam int CF = 64;

    localparam logic [AF-1:0] A0 = 32'hA0A0_0000;
    localparam logic [AF-1:0] A1 = 32'hA1A1_1111;
    localparam logic [BF-1:0] B0 = 32'hB0B0_0000;
    localparam logic [BF-1:0] B1 = 32'hB1B1_1111;
    localparam logic [CF-1:0] CD = 64'hC0FF_EE00_1234_5678;

    // {grant_valid, grant_id, job_done, a_ready, b_ready, out_valid, mm_a_valid, mm_b_valid, mm_out_ready}
    localparam logic [12:0] E0     = 13'b0;
    localparam logic [12:0] E_AB   = {1'b1, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b1, 1'b1, 1'b1};
    localparam logic [12:0] E_C    = {1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1};
    localparam logic [12:0] E_CN   = {1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0};
    localparam logic [12:0] E_DONE = {1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1};

    logic          clk;
    logic          rst;
    logic [1:0]    job_req;
    logic [1:0]    job_done;
    logic          grant_valid;
    logic [0:0]    grant_id;
    logic [2*AF-1:0] req_a_data;
    logic [1:0]    req_a_valid;
    logic [1:0]    req_a_ready;
    logic [2*BF-1:0] req_b_data;
    logic [1:0]    req_b_valid;
    logic [1:0]    req_b_ready;
    logic [CF-1:0] req_out_data;
    logic [1:0]    req_out_valid;
    logic [1:0]    req_out_ready;
    logic [AF-1:0] mm_a_data;
    logic          mm_a_valid;
    logic          mm_a_ready;
    logic [BF-1:0] mm_b_data;
    logic          mm_b_valid;
    logic          mm_b_ready;
    logic [CF-1:0] mm_out_data;
    logic          mm_out_valid;
    logic          mm_out_ready;

    matmul_job_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .job_req       (job_req),
        .job_done      (job_done),
        .grant_valid   (grant_valid),
        .grant_id      (grant_id),
        .req_a_data    (req_a_data),
        .req_a_valid   (req_a_valid),
        .req_a_ready   (req_a_ready),
        .req_b_data    (req_b_data),
        .req_b_valid   (req_b_valid),
        .req_b_ready   (req_b_ready),
        .req_out_data  (req_out_data),
        .req_out_valid (req_out_valid),
        .req_out_ready (req_out_ready),
        .mm_a_data     (mm_a_data),
        .mm_a_valid    (mm_a_valid),
        .mm_a_ready    (mm_a_ready),
        .mm_b_data     (mm_b_data),
        .mm_b_valid    (mm_b_valid),
        .mm_b_ready    (mm_b_ready),
        .mm_out_data   (mm_out_data),
        .mm_out_valid  (mm_out_valid),
        .mm_out_ready  (mm_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [12:0] obs;
    assign obs = {grant_valid, grant_id, job_done, req_a_ready, req_b_ready, req_out_valid,
                  mm_a_valid, mm_b_valid, mm_out_ready};

    int total;
    int bad;

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  av;
        logic [1:0]  bv;
        logic [1:0]  ordy;
        logic        mov;
        logic [12:0] exp;
    } vec_t;

    vec_t tbl[23];

    function automatic vec_t mk(input logic [1:0] req, input logic [1:0] av, input logic [1:0] bv,
                                input logic [1:0] ordy, input logic mov, input logic [12:0] ex);
        vec_t v;
        v.req = req; v.av = av; v.bv = bv; v.ordy = ordy; v.mov = mov; v.exp = ex;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_all(input logic [1:0] req, input logic [1:0] av, input logic [1:0] bv,
                             input logic [1:0] ordy, input logic mov);
        job_req       = req;
        req_a_valid   = av;
        req_b_valid   = bv;
        req_out_ready = ordy;
        mm_out_valid  = mov;
        mm_a_ready    = 1'b1;
        mm_b_ready    = 1'b1;
    endtask

    // One complete job with both requesters asking; checks owner, isolation and beat counts.
    task automatic run_job(input int exp_owner, input int n);
        int  a_hs;
        int  b_hs;
        int  c_hs;
        int  owner;
        bit  seen_grant;
        bit  done_seen;
        bit  iso_ok;
        a_hs = 0; b_hs = 0; c_hs = 0; owner = 0;
        seen_grant = 1'b0; done_seen = 1'b0; iso_ok = 1'b1;
        drive_all(2'b11, 2'b11, 2'b11, 2'b11, 1'b0);
        for (int cyc = 0; cyc < 40 && !done_seen; cyc++) begin
            @(negedge clk);
            if (grant_valid) begin
                if (!seen_grant) begin
                    seen_grant = 1'b1;
                    owner = int'(grant_id);
                    check($sformatf("job%0d_owner", n), 64'(owner), 64'(exp_owner));
                end
                if (req_a_ready[1-owner] || req_b_ready[1-owner] || req_out_valid[1-owner]) iso_ok = 1'b0;
                if (mm_a_valid && mm_a_data !== ((owner == 0) ? A0 : A1)) iso_ok = 1'b0;
                if (mm_b_valid && mm_b_data !== ((owner == 0) ? B0 : B1)) iso_ok = 1'b0;
                if (req_out_valid[owner] && req_out_data !== CD) iso_ok = 1'b0;
            end
            if (mm_a_valid && mm_a_ready) a_hs++;
            if (mm_b_valid && mm_b_ready) b_hs++;
            if (mm_out_valid && mm_out_ready) c_hs++;
            if (job_done != 2'b00) begin
                done_seen = 1'b1;
                check($sformatf("job%0d_done", n), 64'(job_done), 64'(2'b01 << exp_owner));
                check($sformatf("job%0d_a_beats", n), 64'(a_hs), 64'd4);
                check($sformatf("job%0d_b_beats", n), 64'(b_hs), 64'd4);
                check($sformatf("job%0d_c_beats", n), 64'(c_hs), 64'd4);
                check($sformatf("job%0d_isolation", n), 64'(iso_ok), 64'd1);
            end else begin
                @(posedge clk); #1;
                mm_out_valid = (a_hs >= 4 && b_hs >= 4);
            end
        end
        if (!done_seen) begin
            total++; bad++;
            $display("FAIL job%0d_timeout: got no job_done expected done within 40 cycles", n);
        end
        @(posedge clk); #1;
        mm_out_valid = 1'b0;
        @(negedge clk);
        check($sformatf("job%0d_idle_gap", n), 64'(grant_valid), 64'd0);
    endtask

    initial begin
        int a_hs;
        int exp_order[4];
        total = 0;
        bad   = 0;
        req_a_data  = {A1, A0};
        req_b_data  = {B1, B0};
        mm_out_data = CD;

        // Reset with every input asserted: all outputs must stay low.
        rst = 1'b0;
        drive_all(2'b11, 2'b11, 2'b11, 2'b11, 1'b1);
        @(negedge clk);
        check("reset_outputs", 64'(obs), 64'(E0));
        drive_all(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Single requester job (5th A/B beat offered), idle drop, then C-ready toggling.
        tbl[0]  = mk(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, E0);
        tbl[1]  = mk(2'b01, 2'b01, 2'b01, 2'b01, 1'b0, E0);
        tbl[2]  = mk(2'b01, 2'b01, 2'b01, 2'b01, 1'b0, E_AB);
        tbl[3]  = mk(2'b01, 2'b01, 2'b01, 2'b01, 1'b0, E_AB);
        tbl[4]  = mk(2'b01, 2'b01, 2'b01, 2'b01, 1'b0, E_AB);
        tbl[5]  = mk(2'b01, 2'b01, 2'b01, 2'b01, 1'b0, E_AB);
        tbl[6]  = mk(2'b01, 2'b01, 2'b01, 2'b01, 1'b1, E_C);
        tbl[7]  = mk(2'b01, 2'b01, 2'b01, 2'b01, 1'b1, E_C);
        tbl[8]  = mk(2'b01, 2'b01, 2'b01, 2'b01, 1'b1, E_C);
        tbl[9]  = mk(2'b01, 2'b01, 2'b01, 2'b01, 1'b1, E_DONE);
        tbl[10] = mk(2'b01, 2'b00, 2'b00, 2'b00, 1'b1, E0);
        tbl[11] = mk(2'b01, 2'b01, 2'b01, 2'b01, 1'b0, E_AB);
        tbl[12] = mk(2'b01, 2'b01, 2'b01, 2'b01, 1'b0, E_AB);
        tbl[13] = mk(2'b01, 2'b01, 2'b01, 2'b01, 1'b0, E_AB);
        tbl[14] = mk(2'b01, 2'b01, 2'b01, 2'b01, 1'b0, E_AB);
        tbl[15] = mk(2'b01, 2'b00, 2'b00, 2'b01, 1'b1, E_C);
        tbl[16] = mk(2'b01, 2'b00, 2'b00, 2'b00, 1'b1, E_CN);
        tbl[17] = mk(2'b01, 2'b00, 2'b00, 2'b01, 1'b1, E_C);
        tbl[18] = mk(2'b01, 2'b00, 2'b00, 2'b00, 1'b1, E_CN);
        tbl[19] = mk(2'b01, 2'b00, 2'b00, 2'b01, 1'b1, E_C);
        tbl[20] = mk(2'b01, 2'b00, 2'b00, 2'b00, 1'b1, E_CN);
        tbl[21] = mk(2'b01, 2'b00, 2'b00, 2'b01, 1'b1, E_DONE);
        tbl[22] = mk(2'b00, 2'b00, 2'b00, 2'b01, 1'b1, E0);

        for (int i = 0; i < 23; i++) begin
            @(posedge clk); #1;
            drive_all(tbl[i].req, tbl[i].av, tbl[i].bv, tbl[i].ordy, tbl[i].mov);
            @(negedge clk);
            check($sformatf("vec%0d", i), 64'(obs), 64'(tbl[i].exp));
        end

        // Both requesters held from reset.
        @(posedge clk); #1;
        rst = 1'b0;
        drive_all(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
`ifdef MATMUL_ARB_FIXED_PRIORITY_EN
        exp_order = '{0, 0, 0, 0};
`else
        exp_order = '{0, 1, 0, 1};
`endif
        for (int j = 0; j < 4; j++) run_job(exp_order[j], j);

        // Reset after two A beats, then a fresh job must accept exactly four A beats.
        @(posedge clk); #1;
        drive_all(2'b01, 2'b01, 2'b00, 2'b00, 1'b0);
        a_hs = 0;
        for (int cyc = 0; cyc < 10 && a_hs < 2; cyc++) begin
            @(negedge clk);
            if (mm_a_valid && mm_a_ready) a_hs++;
        end
        check("pre_reset_a_beats", 64'(a_hs), 64'd2);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midjob_reset_outputs", 64'(obs), 64'(E0));
        @(posedge clk); #1;
        rst = 1'b1;
        a_hs = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (mm_a_valid && mm_a_ready) a_hs++;
        end
        check("post_reset_grant_id", 64'(grant_id), 64'd0);
        check("post_reset_a_beats", 64'(a_hs), 64'd4);

        drive_all(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog");
    end

endmodule
